tempo_pulse_gen: RTL and testbench

- Produces the single-cycle beat_pulse that advances the sequencer's measure counter, at a user-set tempo in BPM.
- Tempo is adjusted with up/down buttons; a beat period in clk ticks is derived by an iterative divider.
- Sits between button inputs and the measure counter; shares the 10 kHz system clk and play signal.

---
 rtl/tempo_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_tempo_pulse_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempo_pulse_gen.sv
// Beat pulse generator: button-adjusted BPM, period = CLK_HZ*60/bpm via a 20-step restoring divider.
// Optional PLAY_DOWNBEAT_EN: a rising edge of play emits an immediate downbeat pulse.
module tempo_pulse_gen #(
  parameter int CLK_HZ      = 10000,
  parameter int BPM_MIN     = 60,
  parameter int BPM_MAX     = 240,
  parameter int BPM_STEP    = 5,
  parameter int BPM_DEFAULT = 120
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       play,
  input  logic       bpm_up,
  input  logic       bpm_down,
  output logic       beat_pulse,
  output logic [7:0] bpm,
  output logic       busy
);

  localparam int NW    = 20;
  localparam int PW    = 14;
  localparam int ITERS = 20;
  localparam logic [NW-1:0] NUMER          = NW'(CLK_HZ * 60);
  localparam logic [PW-1:0] PERIOD_DEFAULT = PW'((CLK_HZ * 60) / BPM_DEFAULT);

  typedef enum logic {IDLE, DIVIDE} div_state_t;

  div_state_t state, state_next;

  logic          up_sync1, up_sync2, up_prev;
  logic          dn_sync1, dn_sync2, dn_prev;
  logic          up_edge, dn_edge;
  logic [8:0]    bpm_sum;
  logic [7:0]    bpm_cand;
  logic          bpm_change;
  logic [7:0]    rem;
  logic [NW-1:0] quo;
  logic [4:0]    iter;
  logic [8:0]    rem_shift;
  logic          q_bit;
  logic [7:0]    rem_next;
  logic          last_iter;
  logic [PW-1:0] period;
  logic [PW-1:0] count;
`ifdef PLAY_DOWNBEAT_EN
  logic          play_prev;
`endif

  // Two-flop synchronizers plus previous-sample flops for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      up_sync1 <= 1'b0;
      up_sync2 <= 1'b0;
      up_prev  <= 1'b0;
      dn_sync1 <= 1'b0;
      dn_sync2 <= 1'b0;
      dn_prev  <= 1'b0;
    end else begin
      up_sync1 <= bpm_up;
      up_sync2 <= up_sync1;
      up_prev  <= up_sync2;
      dn_sync1 <= bpm_down;
      dn_sync2 <= dn_sync1;
      dn_prev  <= dn_sync2;
    end
  end

  assign up_edge = up_sync2 & ~up_prev;
  assign dn_edge = dn_sync2 & ~dn_prev;
  assign bpm_sum = {1'b0, bpm} + 9'(BPM_STEP);

  always_comb begin
    bpm_cand = bpm;
    if (up_edge && !dn_edge) begin
      bpm_cand = (bpm_sum > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_sum[7:0];
    end else if (dn_edge && !up_edge) begin
      bpm_cand = (bpm < 8'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm - 8'(BPM_STEP);
    end
  end

  // Only a real tempo change while idle starts a divide; edges during busy are dropped
  assign bpm_change = (state == IDLE) && (bpm_cand != bpm);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bpm_change) state_next = DIVIDE;
      DIVIDE:  if (last_iter)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == DIVIDE);
    last_iter = (state == DIVIDE) && (iter == 5'(ITERS - 1));
  end

  // Restoring divide step: remainder stays below bpm, so 8 bits suffice
  assign rem_shift = {rem, quo[NW-1]};
  assign q_bit     = (rem_shift >= {1'b0, bpm});
  assign rem_next  = q_bit ? 8'(rem_shift - {1'b0, bpm}) : rem_shift[7:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bpm    <= 8'(BPM_DEFAULT);
      rem    <= '0;
      quo    <= '0;
      iter   <= '0;
      period <= PERIOD_DEFAULT;
    end else if (bpm_change) begin
      bpm  <= bpm_cand;
      rem  <= '0;
      quo  <= NUMER;
      iter <= '0;
    end else if (state == DIVIDE) begin
      rem  <= rem_next;
      quo  <= {quo[NW-2:0], q_bit};
      iter <= iter + 5'd1;
      if (last_iter) period <= {quo[PW-2:0], q_bit};
    end
  end

  // A count at or beyond the terminal value also wraps, so a shrinking period fires at once
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count      <= '0;
      beat_pulse <= 1'b0;
`ifdef PLAY_DOWNBEAT_EN
      play_prev  <= 1'b0;
`endif
    end else begin
`ifdef PLAY_DOWNBEAT_EN
      play_prev <= play;
`endif
      if (!play) begin
        count      <= '0;
        beat_pulse <= 1'b0;
`ifdef PLAY_DOWNBEAT_EN
      end else if (!play_prev) begin
        count      <= '0;
        beat_pulse <= 1'b1;
`endif
      end else if (count >= period - 14'd1) begin
        count      <= '0;
        beat_pulse <= 1'b1;
      end else begin
        count      <= count + 14'd1;
        beat_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tempo_pulse_gen.sv
// Self-checking bench for tempo_pulse_gen: randomized button/play timing against a BPM arithmetic model.
module tb_tempo_pulse_gen;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       play;
  logic       bpm_up;
  logic       bpm_down;
  logic       beat_pulse;
  logic [7:0] bpm;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses[$];
  int busy_cycles = 0;
  int busy_fall = 0;
  logic busy_prev = 1'b0;
  int model_bpm;
  int off = 0;

  tempo_pulse_gen dut (
    .clk(clk), .n_rst(n_rst), .play(play), .bpm_up(bpm_up), .bpm_down(bpm_down),
    .beat_pulse(beat_pulse), .bpm(bpm), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pulse cycles, busy occupancy and the cycle busy falls
  always @(negedge clk) begin
    if (beat_pulse === 1'b1) pulses.push_back(cyc);
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (busy_prev && !busy) busy_fall <= cyc;
    busy_prev <= busy;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int step_model(input int b, input bit up, input bit dn);
    int r = b;
    if (up && !dn) r = (b + 5 > 240) ? 240 : b + 5;
    else if (dn && !up) r = (b - 5 < 60) ? 60 : b - 5;
    return r;
  endfunction

  function automatic int period_of(input int b);
    return 600000 / b;
  endfunction

  // Index of the first regular (non-downbeat) pulse recorded from p0 onward
  function automatic int first_regular(input int p0);
`ifdef PLAY_DOWNBEAT_EN
    return p0 + 1;
`else
    return p0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    bpm_up = up;
    bpm_down = dn;
    tick(hold);
    bpm_up = 1'b0;
    bpm_down = 1'b0;
  endtask

  task automatic restart_play(output int c0);
    play = 1'b0;
    tick(2);
    play = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; play = 1'b0; bpm_up = 1'b0; bpm_down = 1'b0;
    tick(3);
    checks++;
    if (bpm !== 8'd120) begin errors++; $display("[TB] FAIL reset_bpm: got %0d expected 120", bpm); end
    checks++;
    if (busy !== 1'b0 || beat_pulse !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got busy=%b beat=%b expected 0 0", busy, beat_pulse);
    end
    n_rst = 1'b1;
    tick(2);
    model_bpm = 120;
  endtask

  task automatic test_default_tempo;
    int c0, p0, i0, n, per;
    per = period_of(model_bpm);
    p0 = pulses.size();
    play = 1'b1;
    c0 = cyc;
    tick(16000);
    i0 = first_regular(p0);
`ifdef PLAY_DOWNBEAT_EN
    checks++;
    if (pulses.size() <= p0 || pulses[p0] != c0 + 1) begin
      errors++; $display("[TB] FAIL downbeat_first: got %0d pulses expected one at %0d", pulses.size() - p0, c0 + 1);
    end
`endif
    n = pulses.size() - i0;
    checks++;
    if (n != 3) begin errors++; $display("[TB] FAIL default_count: got %0d expected 3", n); end
    if (n >= 1) begin
      off = pulses[i0] - c0 - per;
      checks++;
      if (off < -1 || off > 1) begin errors++; $display("[TB] FAIL default_first: got %0d expected %0d", pulses[i0] - c0, per); end
    end
    for (int k = 1; k < n; k++) begin
      checks++;
      if (pulses[i0 + k] - pulses[i0 + k - 1] != per) begin
        errors++; $display("[TB] FAIL default_spacing: got %0d expected %0d", pulses[i0 + k] - pulses[i0 + k - 1], per);
      end
    end
    checks++;
    if (bpm !== 8'(model_bpm) || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL default_state: got bpm=%0d busy=%b expected %0d 0", bpm, busy, model_bpm);
    end
  endtask

  task automatic test_bpm_up;
    int b0, p0, per;
    b0 = busy_cycles;
    press(1'b1, 1'b0, 50);
    model_bpm = step_model(model_bpm, 1'b1, 1'b0);
    tick(40);
    checks++;
    if (bpm !== 8'(model_bpm)) begin errors++; $display("[TB] FAIL up_bpm: got %0d expected %0d", bpm, model_bpm); end
    checks++;
    if (busy_cycles - b0 != 20) begin errors++; $display("[TB] FAIL up_busy_len: got %0d expected 20", busy_cycles - b0); end
    per = period_of(model_bpm);
    p0 = pulses.size();
    tick(2 * per + 100);
    checks++;
    if (pulses.size() - p0 < 2) begin
      errors++; $display("[TB] FAIL up_pulse_count: got %0d expected at least 2", pulses.size() - p0);
    end
    for (int k = p0 + 1; k < pulses.size(); k++) begin
      checks++;
      if (pulses[k] - pulses[k - 1] != per) begin
        errors++; $display("[TB] FAIL up_spacing: got %0d expected %0d", pulses[k] - pulses[k - 1], per);
      end
    end
  endtask

  task automatic test_down_clamp;
    int b0;
    for (int i = 0; i < 40; i++) begin
      press(1'b0, 1'b1, $urandom_range(1, 12));
      model_bpm = step_model(model_bpm, 1'b0, 1'b1);
      tick(30);
      checks++;
      if (bpm !== 8'(model_bpm)) begin errors++; $display("[TB] FAIL down_step%0d: got %0d expected %0d", i, bpm, model_bpm); end
    end
    b0 = busy_cycles;
    press(1'b0, 1'b1, 5);
    tick(30);
    checks++;
    if (busy_cycles != b0 || bpm !== 8'd60) begin
      errors++; $display("[TB] FAIL down_limit: got bpm=%0d busy_cycles=%0d expected 60 0", bpm, busy_cycles - b0);
    end
  endtask

  task automatic test_simultaneous;
    int b0;
    b0 = busy_cycles;
    press(1'b1, 1'b1, $urandom_range(3, 15));
    tick(30);
    checks++;
    if (bpm !== 8'(model_bpm)) begin errors++; $display("[TB] FAIL both_bpm: got %0d expected %0d", bpm, model_bpm); end
    checks++;
    if (busy_cycles != b0) begin errors++; $display("[TB] FAIL both_busy: got %0d expected 0", busy_cycles - b0); end
  endtask

  task automatic test_shrink_normal;
    int c0, p0, i0, w, per;
    restart_play(c0);
    p0 = pulses.size();
    w = $urandom_range(5000, 7000);
    tick(w);
    press(1'b1, 1'b0, 5);
    model_bpm = step_model(model_bpm, 1'b1, 1'b0);
    per = period_of(model_bpm);
    tick(per - w + 20);
    i0 = first_regular(p0);
    checks++;
    if (pulses.size() - i0 != 1) begin
      errors++; $display("[TB] FAIL shrink_normal_count: got %0d expected 1", pulses.size() - i0);
    end else begin
      checks++;
      if (pulses[i0] != c0 + per + off) begin
        errors++; $display("[TB] FAIL shrink_normal_time: got %0d expected %0d", pulses[i0] - c0, per + off);
      end
    end
  endtask

  task automatic test_shrink_terminal;
    int c0, p0, i0, per;
    press(1'b0, 1'b1, 5);
    model_bpm = step_model(model_bpm, 1'b0, 1'b1);
    tick(30);
    checks++;
    if (bpm !== 8'(model_bpm)) begin errors++; $display("[TB] FAIL terminal_setup: got %0d expected %0d", bpm, model_bpm); end
    restart_play(c0);
    p0 = pulses.size();
    tick($urandom_range(9400, 9700));
    press(1'b1, 1'b0, 5);
    model_bpm = step_model(model_bpm, 1'b1, 1'b0);
    per = period_of(model_bpm);
    tick(40);
    i0 = first_regular(p0);
    checks++;
    if (pulses.size() - i0 != 1) begin
      errors++; $display("[TB] FAIL terminal_count: got %0d expected 1", pulses.size() - i0);
    end else begin
      checks++;
      if (pulses[i0] - busy_fall != 1) begin
        errors++; $display("[TB] FAIL terminal_latency: got %0d expected 1", pulses[i0] - busy_fall);
      end
      tick(per);
      checks++;
      if (pulses.size() - i0 < 2 || pulses[i0 + 1] - pulses[i0] != per) begin
        errors++; $display("[TB] FAIL terminal_spacing: got %0d pulses expected next after %0d", pulses.size() - i0, per);
      end
    end
  endtask

  task automatic test_pause;
    int c0, p0, i0, per;
    per = period_of(model_bpm);
    tick($urandom_range(1000, 3000));
    play = 1'b0;
    p0 = pulses.size();
    tick($urandom_range(200, 800));
    checks++;
    if (pulses.size() != p0) begin errors++; $display("[TB] FAIL pause_quiet: got %0d expected 0", pulses.size() - p0); end
    play = 1'b1;
    c0 = cyc;
    p0 = pulses.size();
    tick(per + 20);
`ifdef PLAY_DOWNBEAT_EN
    checks++;
    if (pulses.size() <= p0 || pulses[p0] != c0 + 1) begin
      errors++; $display("[TB] FAIL resume_downbeat: got %0d pulses expected one at %0d", pulses.size() - p0, c0 + 1);
    end
`endif
    i0 = first_regular(p0);
    checks++;
    if (pulses.size() - i0 != 1) begin
      errors++; $display("[TB] FAIL resume_count: got %0d expected 1", pulses.size() - i0);
    end else begin
      checks++;
      if (pulses[i0] != c0 + per + off) begin
        errors++; $display("[TB] FAIL resume_time: got %0d expected %0d", pulses[i0] - c0, per + off);
      end
    end
  endtask

  task automatic test_reset_mid_divide;
    int n = 0;
    bpm_up = 1'b1;
    while (busy !== 1'b1 && n < 30) begin tick(1); n++; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL middiv_start: got busy=%b expected 1", busy); end
    tick($urandom_range(1, 15));
    n_rst = 1'b0;
    #1;
    checks++;
    if (bpm !== 8'd120 || busy !== 1'b0 || beat_pulse !== 1'b0) begin
      errors++; $display("[TB] FAIL middiv_reset: got bpm=%0d busy=%b beat=%b expected 120 0 0", bpm, busy, beat_pulse);
    end
    bpm_up = 1'b0;
    tick(3);
    n_rst = 1'b1;
    model_bpm = 120;
    tick(40);
    checks++;
    if (bpm !== 8'(model_bpm) || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL middiv_after: got bpm=%0d busy=%b expected %0d 0", bpm, busy, model_bpm);
    end
  endtask

  initial begin
    test_reset();
    test_default_tempo();
    test_bpm_up();
    test_down_clamp();
    test_simultaneous();
    test_shrink_normal();
    test_shrink_terminal();
    test_pause();
    test_reset_mid_divide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
